// File: rtl/data18_row_reader.sv
// data18_row_reader: circular one-row delay line that returns the pixel directly above the incoming one
module data18_row_reader #(
  parameter int ROW_LEN = 28,
  parameter int COL_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             din_valid,
  input  logic [17:0]      din,
  output logic [17:0]      dout,
  output logic             dout_valid,
  output logic [COL_W-1:0] dout_col,
  output logic             fill_done
);
  localparam int AW = ROW_LEN > 1 ? $clog2(ROW_LEN) : 1;
  localparam int FW = $clog2(ROW_LEN + 1);
  logic [17:0]      r_mem [2**AW];
  logic [COL_W-1:0] r_wptr;
  logic [COL_W-1:0] w_wnext;
  logic [AW-1:0]    w_waddr;
  logic [FW-1:0]    r_fill;
  logic [17:0]      w_rdata;
  logic             w_emit;
  assign fill_done = r_fill == FW'(ROW_LEN);
  assign w_rdata   = r_mem[r_wptr[AW-1:0]];
  assign w_emit    = din_valid && fill_done && !frame_start;
  assign w_wnext   = r_wptr == COL_W'(ROW_LEN - 1) ? '0 : r_wptr + COL_W'(1);
  assign w_waddr   = frame_start ? '0 : r_wptr[AW-1:0];
  // async read of the old word happens before the write lands at the edge
  always_ff @(posedge clk)
    if (din_valid && !reset) r_mem[w_waddr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_fill     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_col   <= '0;
    end else begin
      dout_valid <= w_emit;
      if (w_emit) begin
        dout     <= w_rdata;
        dout_col <= r_wptr;
      end
      if (frame_start) begin
        r_wptr <= din_valid && ROW_LEN > 1 ? COL_W'(1) : '0;
        r_fill <= FW'(din_valid);
      end else if (din_valid) begin
        r_wptr <= w_wnext;
        if (!fill_done) r_fill <= r_fill + FW'(1);
      end
    end
  end
endmodule
